mem_port_arbiter: RTL and testbench

//  Shares the single-port 1K-word data/instruction RAM between the IF stage (fetch, read-only)
//  and the MEM stage (load/store). Grants one access per cycle, generates byte enables from

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch and load/store.
// MEM has fixed priority over IF. The RAM answers one cycle after the address, and the
// response is steered back to whichever stage owned the access.
// Optional build macro ARB_STARVE_GUARD_EN: IF is force-granted after STARVE_LIMIT denied cycles.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  i_CLK,
  input  logic                  i_RST,
  input  logic                  i_IFReq,
  input  logic [31:0]           i_IFAddr,
  input  logic                  i_Flush,
  output logic                  o_IFGnt,
  output logic                  o_IFRValid,
  output logic [31:0]           o_IFRData,
  input  logic                  i_MemReq,
  input  logic                  i_MemWrite,
  input  logic [31:0]           i_MemAddr,
  input  logic [2:0]            i_LSWidth,
  input  logic                  i_SignExt,
  input  logic [31:0]           i_MemWData,
  output logic                  o_MemGnt,
  output logic                  o_MemRValid,
  output logic [31:0]           o_MemRData,
  output logic                  o_Misalign,
  output logic                  o_IFStall,
  output logic                  o_MemStall,
  output logic [ADDR_WIDTH-1:0] o_RamAddr,
  output logic                  o_RamWE,
  output logic [3:0]            o_RamBE,
  output logic [31:0]           o_RamWData,
  input  logic [31:0]           i_RamRData
);

  localparam logic [2:0] W_BYTE = 3'd1;
  localparam logic [2:0] W_HALF = 3'd2;
  localparam logic [2:0] W_WORD = 3'd3;

  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_MEM} state_t;

  state_t      state;
  logic [1:0]  lat_off;
  logic [2:0]  lat_width;
  logic        lat_sext;
  logic        flush_q;

  logic        force_if_c;
  logic        mem_gnt_c;
  logic        if_gnt_c;
  logic        misalign_c;
  logic [3:0]  mem_be_c;
  logic [1:0]  mem_off_c;
  logic [31:0] shifted_c;
  logic [31:0] load_data_c;
  logic        unused_c;

  assign mem_off_c = i_MemAddr[1:0];
  assign unused_c  = ^{i_IFAddr[31:ADDR_WIDTH+2], i_IFAddr[1:0], i_MemAddr[31:ADDR_WIDTH+2]};

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] starve_cnt;

  // Count cycles IF sits requesting without a grant; saturates at the limit
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      starve_cnt <= '0;
    end else if (if_gnt_c) begin
      starve_cnt <= '0;
    end else if (i_IFReq && (starve_cnt < CNT_W'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign force_if_c = i_IFReq && (starve_cnt >= CNT_W'(STARVE_LIMIT));
`else
  localparam int unsigned starve_limit_unused = STARVE_LIMIT;
  assign force_if_c = 1'b0;
`endif

  // Single grant per cycle: MEM first unless IF has starved
  assign mem_gnt_c  = ~i_RST & i_MemReq & ~force_if_c;
  assign if_gnt_c   = ~i_RST & i_IFReq & ~mem_gnt_c;
  assign o_MemGnt   = mem_gnt_c;
  assign o_IFGnt    = if_gnt_c;
  assign o_IFStall  = ~i_RST & i_IFReq & ~if_gnt_c;
  assign o_MemStall = ~i_RST & i_MemReq & ~mem_gnt_c;
  assign o_Misalign = mem_gnt_c & misalign_c;

  // Byte enables and legality of the load/store width at this offset
  always_comb begin
    mem_be_c   = 4'b0000;
    misalign_c = 1'b0;
    case (i_LSWidth)
      W_BYTE:  mem_be_c = 4'b0001 << mem_off_c;
      W_HALF: begin
        mem_be_c   = mem_off_c[1] ? 4'b1100 : 4'b0011;
        misalign_c = mem_off_c[0];
      end
      W_WORD: begin
        mem_be_c   = 4'b1111;
        misalign_c = (mem_off_c != 2'b00);
      end
      default: misalign_c = 1'b1;
    endcase
  end

  // Drive the RAM port from the granted requester; idle on misalign or no grant
  always_comb begin
    o_RamAddr  = '0;
    o_RamWE    = 1'b0;
    o_RamBE    = 4'b0000;
    o_RamWData = '0;
    if (mem_gnt_c && !misalign_c) begin
      o_RamAddr = i_MemAddr[ADDR_WIDTH+1:2];
      o_RamWE   = i_MemWrite;
      o_RamBE   = mem_be_c;
      case (i_LSWidth)
        W_BYTE:  o_RamWData = {4{i_MemWData[7:0]}};
        W_HALF:  o_RamWData = {2{i_MemWData[15:0]}};
        default: o_RamWData = i_MemWData;
      endcase
    end else if (if_gnt_c) begin
      o_RamAddr = i_IFAddr[ADDR_WIDTH+1:2];
      o_RamBE   = 4'b1111;
    end
  end

  // Response-owner FSM; a new grant may issue during the response cycle
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state     <= IDLE;
      lat_off   <= 2'b00;
      lat_width <= 3'd0;
      lat_sext  <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      flush_q <= 1'b0;
      if (mem_gnt_c) begin
        state     <= (!i_MemWrite && !misalign_c) ? RESP_MEM : IDLE;
        lat_off   <= mem_off_c;
        lat_width <= i_LSWidth;
        lat_sext  <= i_SignExt;
      end else if (if_gnt_c) begin
        state   <= RESP_IF;
        flush_q <= i_Flush;
      end else begin
        state <= IDLE;
      end
    end
  end

  // Align the returned word to the latched offset and extend to 32 bits
  always_comb begin
    shifted_c = i_RamRData >> {lat_off, 3'b000};
    case (lat_width)
      W_BYTE:  load_data_c = {{24{lat_sext & shifted_c[7]}}, shifted_c[7:0]};
      W_HALF:  load_data_c = {{16{lat_sext & shifted_c[15]}}, shifted_c[15:0]};
      default: load_data_c = shifted_c;
    endcase
  end

  assign o_IFRValid  = (state == RESP_IF) & ~flush_q & ~i_Flush;
  assign o_IFRData   = (state == RESP_IF) ? i_RamRData : 32'd0;
  assign o_MemRValid = (state == RESP_MEM);
  assign o_MemRData  = (state == RESP_MEM) ? load_data_c : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural RAM behind the port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, flush, mem_req, mem_write, sign_ext;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [2:0]  ls_width;
  logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, misalign, if_stall, mem_stall;
  logic [31:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram [0:1023];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .i_CLK(clk), .i_RST(rst),
    .i_IFReq(if_req), .i_IFAddr(if_addr), .i_Flush(flush),
    .o_IFGnt(if_gnt), .o_IFRValid(if_rvalid), .o_IFRData(if_rdata),
    .i_MemReq(mem_req), .i_MemWrite(mem_write), .i_MemAddr(mem_addr),
    .i_LSWidth(ls_width), .i_SignExt(sign_ext), .i_MemWData(mem_wdata),
    .o_MemGnt(mem_gnt), .o_MemRValid(mem_rvalid), .o_MemRData(mem_rdata),
    .o_Misalign(misalign), .o_IFStall(if_stall), .o_MemStall(mem_stall),
    .o_RamAddr(ram_addr), .o_RamWE(ram_we), .o_RamBE(ram_be),
    .o_RamWData(ram_wdata), .i_RamRData(ram_rdata)
  );

  // Behavioural single-port RAM, one-cycle read latency, byte-lane writes
  always @(posedge clk) begin
    ram_rdata <= ram[ram_addr];
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; flush = 0; mem_req = 0; mem_write = 0; sign_ext = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; ls_width = 3'd3;
  endtask

  task automatic test_reset();
    rst = 1; if_req = 1; mem_req = 1;
    @(negedge clk);
    if ({if_gnt, mem_gnt, if_rvalid, mem_rvalid, misalign} !== 5'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b want 00000", {if_gnt, mem_gnt, if_rvalid, mem_rvalid, misalign});
    end
    vectors++;
    if ({ram_we, ram_be} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ram: got %b want 00000", {ram_we, ram_be});
    end
    vectors++;
    step(); idle_inputs(); rst = 0; step();
  endtask

  task automatic test_fetch(input logic [31:0] addr, input string tag);
    if_req = 1; if_addr = addr;
    @(negedge clk);
    if (if_gnt !== 1'b1 || ram_addr !== 10'd4) begin
      miscompares++; $display("FAIL %s_gnt: got gnt=%b addr=%h want gnt=1 addr=004", tag, if_gnt, ram_addr);
    end
    vectors++;
    step(); if_req = 0;
    @(negedge clk);
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093 || mem_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL %s_data: got v=%b d=%h mv=%b want v=1 d=00500093 mv=0", tag, if_rvalid, if_rdata, mem_rvalid);
    end
    vectors++;
    step();
  endtask

  task automatic test_starve();
    int gnt_cycle = -1;
    int want_cycle;
    logic stall_at_gnt = 0;
`ifdef ARB_STARVE_GUARD_EN
    want_cycle = 4;
`else
    want_cycle = -1;
`endif
    if_req = 1; if_addr = 32'h10; mem_req = 1; mem_addr = 0; ls_width = 3'd3;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if_gnt === 1'b1 && gnt_cycle < 0) begin
        gnt_cycle = c; stall_at_gnt = mem_stall;
      end
      step();
      if (gnt_cycle >= 0) if_req = 0;
    end
    if (gnt_cycle !== want_cycle) begin
      miscompares++; $display("FAIL starve_cycle: got %0d want %0d", gnt_cycle, want_cycle);
    end
    vectors++;
    if (gnt_cycle >= 0 && stall_at_gnt !== 1'b1) begin
      miscompares++; $display("FAIL starve_memstall: got %b want 1", stall_at_gnt);
    end
    vectors++;
    idle_inputs(); step(); step();
  endtask

  task automatic test_contention();
    if_req = 1; if_addr = 32'h20; mem_req = 1; mem_addr = 32'h40; ls_width = 3'd3;
    @(negedge clk);
    if ({mem_gnt, if_gnt, if_stall} !== 3'b101 || ram_addr !== 10'd16) begin
      miscompares++; $display("FAIL cont_c0: got mg/ig/is=%b addr=%h want 101 addr=010", {mem_gnt, if_gnt, if_stall}, ram_addr);
    end
    vectors++;
    step(); mem_req = 0;
    @(negedge clk);
    if (if_gnt !== 1'b1 || ram_addr !== 10'd8 || mem_rvalid !== 1'b1 || mem_rdata !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL cont_c1: got ig=%b addr=%h mv=%b md=%h want 1 008 1 cafef00d", if_gnt, ram_addr, mem_rvalid, mem_rdata);
    end
    vectors++;
    step(); if_req = 0;
    @(negedge clk);
    if (if_rvalid !== 1'b1 || if_rdata !== 32'h11223344 || mem_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL cont_c2: got iv=%b id=%h mv=%b want 1 11223344 0", if_rvalid, if_rdata, mem_rvalid);
    end
    vectors++;
    step(); idle_inputs();
  endtask

  task automatic test_store_byte();
    mem_req = 1; mem_write = 1; mem_addr = 32'h103; ls_width = 3'd1; mem_wdata = 32'h000000AB;
    @(negedge clk);
    if (ram_addr !== 10'h040 || ram_be !== 4'b1000 || ram_wdata !== 32'hABABABAB || ram_we !== 1'b1 || mem_gnt !== 1'b1) begin
      miscompares++; $display("FAIL store_byte: got a=%h be=%b wd=%h we=%b g=%b want 040 1000 abababab 1 1", ram_addr, ram_be, ram_wdata, ram_we, mem_gnt);
    end
    vectors++;
    step(); mem_write = 0; sign_ext = 1;
    @(negedge clk);
    if (mem_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL store_norvalid: got mv=%b iv=%b want 0 0", mem_rvalid, if_rvalid);
    end
    vectors++;
    step(); mem_req = 0;
    @(negedge clk);
    if (mem_rvalid !== 1'b1 || mem_rdata !== 32'hFFFFFFAB) begin
      miscompares++; $display("FAIL load_byte_sext: got v=%b d=%h want 1 ffffffab", mem_rvalid, mem_rdata);
    end
    vectors++;
    step(); idle_inputs();
  endtask

  task automatic load_check(input logic [31:0] addr, input logic [2:0] w, input logic sx,
                            input logic [3:0] be, input logic [31:0] want, input string tag);
    mem_req = 1; mem_write = 0; mem_addr = addr; ls_width = w; sign_ext = sx;
    @(negedge clk);
    if (ram_be !== be || misalign !== 1'b0) begin
      miscompares++; $display("FAIL %s_be: got be=%b mis=%b want be=%b mis=0", tag, ram_be, misalign, be);
    end
    vectors++;
    step(); idle_inputs();
    @(negedge clk);
    if (mem_rvalid !== 1'b1 || mem_rdata !== want) begin
      miscompares++; $display("FAIL %s_data: got v=%b d=%h want v=1 d=%h", tag, mem_rvalid, mem_rdata, want);
    end
    vectors++;
    step();
  endtask

  task automatic test_loads();
    ram[10'h040] = 32'h80011234;
    load_check(32'h102, 3'd2, 1'b1, 4'b1100, 32'hFFFF8001, "half_sext");
    load_check(32'h102, 3'd2, 1'b0, 4'b1100, 32'h00008001, "half_zext");
    load_check(32'h100, 3'd2, 1'b1, 4'b0011, 32'h00001234, "half_lo");
    load_check(32'h1101, 3'd1, 1'b0, 4'b0010, 32'h00000012, "byte_wrap");
  endtask

  task automatic misalign_check(input logic [31:0] addr, input logic [2:0] w, input string tag);
    mem_req = 1; mem_write = 1; mem_addr = addr; ls_width = w;
    @(negedge clk);
    if ({misalign, mem_gnt, ram_we, ram_be} !== 7'b1100000) begin
      miscompares++; $display("FAIL %s: got mis/gnt/we/be=%b want 1100000", tag, {misalign, mem_gnt, ram_we, ram_be});
    end
    vectors++;
    step(); idle_inputs();
    @(negedge clk);
    if (mem_rvalid !== 1'b0 || misalign !== 1'b0) begin
      miscompares++; $display("FAIL %s_after: got mv=%b mis=%b want 0 0", tag, mem_rvalid, misalign);
    end
    vectors++;
    step();
  endtask

  task automatic test_misalign();
    misalign_check(32'h6, 3'd3, "mis_word");
    misalign_check(32'h1, 3'd2, "mis_half");
    misalign_check(32'h0, 3'd4, "mis_double");
    misalign_check(32'h0, 3'd0, "mis_w0");
  endtask

  task automatic test_flush();
    if_req = 1; if_addr = 32'h10;
    step(); if_req = 0; flush = 1;
    @(negedge clk);
    if (if_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL flush_resp: got %b want 0", if_rvalid);
    end
    vectors++;
    step(); flush = 1; if_req = 1;
    step(); flush = 0; if_req = 0;
    @(negedge clk);
    if (if_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL flush_grant: got %b want 0", if_rvalid);
    end
    vectors++;
    step();
  endtask

  task automatic test_reset_mid();
    mem_req = 1; mem_addr = 32'h40; ls_width = 3'd3;
    step(); idle_inputs(); rst = 1;
    @(negedge clk);
    if (mem_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_during: got %b want 0", mem_rvalid);
    end
    vectors++;
    step(); rst = 0;
    @(negedge clk);
    if (mem_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_after: got mv=%b iv=%b want 0 0", mem_rvalid, if_rvalid);
    end
    vectors++;
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[4]  = 32'h00500093;
    ram[8]  = 32'h11223344;
    ram[16] = 32'hCAFEF00D;
    ram_rdata = 0;
    idle_inputs();
    rst = 1;
    test_reset();
    test_fetch(32'h10, "fetch");
    test_starve();
    test_contention();
    test_store_byte();
    test_loads();
    test_misalign();
    test_flush();
    test_fetch(32'h1010, "fetch_wrap");
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
